// File: rtl/adder_acc_hs.sv
// -----------------------------------------------------------------------------
// adder_acc_hs
// -----------------------------------------------------------------------------
// Purpose:
//   Two-state (IDLE/CALC) operand adder with an optional running accumulator.
//   A ready-qualified sample strobe captures two WIDTH-bit operands plus a mode
//   bit. One cycle later the result is registered onto c and done pulses high
//   for exactly one cycle. In accumulate mode the result also becomes the new
//   accumulator value, and a carry out of the ACC_W-bit accumulator sets the
//   sticky ovf flag.
//
// Handshake (valid/ready):
//   sample acts as valid. A transfer happens on a rising clk edge where
//   sample=1 and ready=1. sample while ready=0 is ignored (no capture, no
//   count). ready is high whenever the FSM is in IDLE, which includes the
//   cycle in which done is high, so a new operation may be accepted on the
//   same edge that retires done (one operation per two cycles).
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
//   GUARD  extra accumulator bits above WIDTH (>= 1); ACC_W = WIDTH + GUARD
//   CNT_W  width of the accepted-operation counter (wraps silently)
//
// Ports:
//   clk        in   1      clock, all state on posedge
//   rst        in   1      asynchronous active-high reset
//   sample     in   1      operand strobe (valid), accepted when ready=1
//   mode       in   1      0 = add (a+b), 1 = accumulate (acc+a+b)
//   acc_clr    in   1      synchronous accumulator / ovf clear
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   ready      out  1      FSM in IDLE, sample will be accepted
//   done       out  1      one-cycle pulse, c holds a fresh result
//   c          out  ACC_W  result, held until the next done
//   ovf        out  1      sticky accumulator carry-out
//   op_cnt     out  CNT_W  number of accepted samples
//   state_dbg  out  1      current FSM state (0 = IDLE, 1 = CALC)
//
// Configuration:
//   ADDER_ACC_SVA_EN  when defined, compiles in-module concurrent assertions.
//                     When undefined no assertion code exists and behaviour
//                     is identical.
// -----------------------------------------------------------------------------
module adder_acc_hs #(
  parameter int WIDTH = 8,
  parameter int GUARD = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample,
  input  logic                   mode,
  input  logic                   acc_clr,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   ready,
  output logic                   done,
  output logic [WIDTH+GUARD-1:0] c,
  output logic                   ovf,
  output logic [CNT_W-1:0]       op_cnt,
  output logic                   state_dbg
);

  localparam int ACC_W = WIDTH + GUARD;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Captured operands; these are the only values the CALC cycle works from,
  // so the a/b/mode inputs are free to change after the accepting edge.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;

  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W-1:0] c_q;
  logic             done_q;
  logic [CNT_W-1:0] op_cnt_q;

  // Combinational helpers
  logic             accept;
  logic             in_calc;
  logic [ACC_W-1:0] add_sum;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] result;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    ready   = 1'b0;
    in_calc = 1'b0;
    case (state_q)
      IDLE:    ready   = 1'b1;
      CALC:    in_calc = 1'b1;
      default: ready   = 1'b0;
    endcase
  end

  assign accept    = sample & ready;
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Plain add: GUARD >= 1 guarantees the WIDTH+1-bit sum fits in ACC_W bits.
  // Accumulate: one extra bit on top of ACC_W catches the carry for ovf.
  always_comb begin
    add_sum = {{GUARD{1'b0}}, a_q} + {{GUARD{1'b0}}, b_q};
    acc_sum = {1'b0, acc_q}
            + {{(GUARD + 1){1'b0}}, a_q}
            + {{(GUARD + 1){1'b0}}, b_q};
    result  = mode_q ? acc_sum[ACC_W-1:0] : add_sum;
  end

  // Operand capture on an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  // Accepted-operation counter; wraps at 2**CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else if (accept) begin
      op_cnt_q <= op_cnt_q + CNT_W'(1);
    end
  end

  // Result register and done pulse. c only loads in CALC, so it holds its
  // value between done pulses. done follows CALC by one edge, and CALC is
  // always followed by IDLE, so done can never be high two cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= in_calc;
      if (in_calc) begin
        c_q <= result;
      end
    end
  end

  // Accumulator and sticky overflow.
  // acc_clr has priority over the accumulate update:
  //  - asserted with an accepted sample (IDLE): acc is zero by the time CALC
  //    reads it, so the pending accumulate starts from 0;
  //  - asserted during CALC: the result on c already used the old acc (the
  //    sum above is combinational from acc_q), but the stored acc/ovf end at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (acc_clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (in_calc && mode_q) begin
      acc_q <= acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign done   = done_q;
  assign c      = c_q;
  assign ovf    = ovf_q;
  assign op_cnt = op_cnt_q;

  // ---------------------------------------------------------------------------
  // Optional in-module assertions
  // ---------------------------------------------------------------------------
`ifdef ADDER_ACC_SVA_EN
  // done is raised on the IDLE cycle that follows CALC, so "done implies not
  // ready" is checked against the cycle that produced the result.
  a_done_after_busy: assert property (
    @(posedge clk) disable iff (rst) done |-> $past(!ready))
    $display("%0t adder_acc_hs: done |-> !ready (producing cycle) held", $time);
  else
    $error("%0t adder_acc_hs: done without a preceding busy cycle", $time);

  a_done_single: assert property (
    @(posedge clk) disable iff (rst) done |=> !done)
    $display("%0t adder_acc_hs: done |=> !done held", $time);
  else
    $error("%0t adder_acc_hs: done high on consecutive cycles", $time);

  // Accept at edge N, done visible after edge N+1: seen two sampling edges on.
  a_accept_done: assert property (
    @(posedge clk) disable iff (rst) (sample && ready) |=> ##1 done)
    $display("%0t adder_acc_hs: accept |=> done held", $time);
  else
    $error("%0t adder_acc_hs: accepted sample produced no done", $time);

  a_known: assert property (
    @(posedge clk) disable iff (rst) !$isunknown({ready, done, c, ovf}))
    $display("%0t adder_acc_hs: outputs known", $time);
  else
    $error("%0t adder_acc_hs: X/Z on outputs", $time);

  // Checked against the captured operands, which are what the add consumed.
  a_add_result: assert property (
    @(posedge clk) disable iff (rst)
    (done && !mode_q) |-> (c == ({{GUARD{1'b0}}, a_q} + {{GUARD{1'b0}}, b_q})))
    $display("%0t adder_acc_hs: add-mode result held", $time);
  else
    $error("%0t adder_acc_hs: add-mode result wrong", $time);
`endif

endmodule
